// File: rtl/pl_reg_stage.sv
// Pipeline stage register with valid/ready handshake, flush, optional two-entry skid buffer
// and a saturating stall-cycle counter. out_data always comes straight from a register.
module pl_reg_stage #(
  parameter int                 DATA_W    = 32,
  parameter int                 SKID      = 1,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              ready_state;
  logic              accept;
  logic              consume;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign occupancy = state;

  // With the skid buffer the ready term only depends on registered state, breaking the
  // combinational ready chain; without it, ready passes out_ready through for full throughput.
  assign in_ready = !flush && ((SKID != 0) ? ready_state : (!out_valid || out_ready));
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= EMPTY;
      main_data   <= RESET_VAL;
      skid_data   <= RESET_VAL;
      ready_state <= 1'b1;
    end else if (flush) begin
      state       <= EMPTY;
      main_data   <= RESET_VAL;
      skid_data   <= RESET_VAL;
      ready_state <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            main_data <= in_data;
          end
        end
        ONE: begin
          if (accept && !consume && (SKID != 0)) begin
            state       <= TWO;
            skid_data   <= in_data;
            ready_state <= 1'b0;
          end else if (accept && consume) begin
            main_data <= in_data;
          end else if (consume) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            state       <= ONE;
            main_data   <= skid_data;
            ready_state <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          ready_state <= 1'b1;
        end
      endcase
    end
  end

  // A flushed cycle is not a stall: the held entry is being killed, not waiting.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
